// File: rtl/int_to_rec_fn_pipe.sv
// Three-stage pipelined 64-bit integer to recoded-double converter with global stall.
// Optional round-to-odd (mode 6) is built only when INT_TO_REC_FN_ROD_EN is defined.
`timescale 1ns/1ps
module int_to_rec_fn_pipe (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [63:0] io_in_bits_in,
   input  logic        io_in_bits_signedIn,
   input  logic [2:0]  io_in_bits_roundingMode,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [64:0] io_out_bits_out,
   output logic [4:0]  io_out_bits_exceptionFlags
);

   typedef enum logic [2:0] {
      RND_NE = 3'd0,
      RND_TZ = 3'd1,
      RND_DN = 3'd2,
      RND_UP = 3'd3,
      RND_MM = 3'd4,
      RND_OD = 3'd5
   } rnd_t;

   logic en;

   logic        s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic        s1_sign_reg, s2_sign_reg;
   logic [63:0] s1_mag_reg, s2_norm_reg;
   rnd_t        s1_rnd_reg, s2_rnd_reg;
   logic [5:0]  s2_p_reg;
   logic        s2_zero_reg;
   logic [64:0] s3_out_reg;
   logic [4:0]  s3_flags_reg;

   logic        s1_sign_next;
   logic [63:0] s1_mag_next;
   rnd_t        s1_rnd_next;
   logic [63:0] s2_norm_next;
   logic [5:0]  s2_lz;
   logic [5:0]  s2_p_next;
   logic        s2_zero_next;
   logic [64:0] s3_out_next;
   logic [4:0]  s3_flags_next;

   // Only S3 occupancy gates the pipeline; bubbles upstream are not collapsed.
   assign en           = ~s3_valid_reg | io_out_ready;
   assign io_in_ready  = en;
   assign io_out_valid = s3_valid_reg;
   assign io_out_bits_out            = s3_out_reg;
   assign io_out_bits_exceptionFlags = s3_flags_reg;

   assign s1_sign_next = io_in_bits_signedIn & io_in_bits_in[63];
   assign s1_mag_next  = s1_sign_next ? (~io_in_bits_in + 64'd1) : io_in_bits_in;

   // Fold the eight encodings down to the distinct behaviours early.
   always_comb begin
      s1_rnd_next = RND_TZ;
      case (io_in_bits_roundingMode)
         3'd0:    s1_rnd_next = RND_NE;
         3'd2:    s1_rnd_next = RND_DN;
         3'd3:    s1_rnd_next = RND_UP;
         3'd4:    s1_rnd_next = RND_MM;
`ifdef INT_TO_REC_FN_ROD_EN
         3'd6:    s1_rnd_next = RND_OD;
`else
         3'd6:    s1_rnd_next = RND_NE;
`endif
         default: s1_rnd_next = RND_TZ;
      endcase
   end

   // Binary-search normaliser: each step shifts out a block of leading zeros.
   always_comb begin
      s2_norm_next = s1_mag_reg;
      s2_lz        = 6'd0;
      for (int k = 5; k >= 0; k--) begin
         if ((s2_norm_next >> (64 - (1 << k))) == 64'd0) begin
            s2_norm_next = s2_norm_next << (1 << k);
            s2_lz[k]     = 1'b1;
         end
      end
   end

   assign s2_p_next    = 6'd63 - s2_lz;
   assign s2_zero_next = (s1_mag_reg == 64'd0);

   logic [52:0] sig;
   logic        guard, sticky, inexact;
   logic        round_inc, force_odd;
   logic [53:0] sig_sum;
   logic        carry;
   logic [11:0] rec_exp;
   logic [51:0] frac;

   assign sig     = s2_norm_reg[63:11];
   assign guard   = s2_norm_reg[10];
   assign sticky  = |s2_norm_reg[9:0];
   assign inexact = guard | sticky;

   always_comb begin
      round_inc = 1'b0;
      case (s2_rnd_reg)
         RND_NE:  round_inc = guard & (sticky | sig[0]);
         RND_MM:  round_inc = guard;
         RND_DN:  round_inc = s2_sign_reg & inexact;
         RND_UP:  round_inc = ~s2_sign_reg & inexact;
         default: round_inc = 1'b0;
      endcase
   end

`ifdef INT_TO_REC_FN_ROD_EN
   assign force_odd = (s2_rnd_reg == RND_OD) & inexact;
`else
   assign force_odd = 1'b0;
`endif

   assign sig_sum = {1'b0, sig[52:1], sig[0] | force_odd} + {53'd0, round_inc};
   assign carry   = sig_sum[53];
   assign rec_exp = 12'h800 + {6'd0, s2_p_reg} + {11'd0, carry};
   assign frac    = carry ? 52'd0 : sig_sum[51:0];

   assign s3_out_next   = s2_zero_reg ? 65'd0 : {s2_sign_reg, rec_exp, frac};
   assign s3_flags_next = {4'b0000, inexact & ~s2_zero_reg};

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         s1_sign_reg  <= 1'b0;
         s1_mag_reg   <= 64'd0;
         s1_rnd_reg   <= RND_NE;
         s2_sign_reg  <= 1'b0;
         s2_norm_reg  <= 64'd0;
         s2_p_reg     <= 6'd0;
         s2_zero_reg  <= 1'b0;
         s2_rnd_reg   <= RND_NE;
         s3_out_reg   <= 65'd0;
         s3_flags_reg <= 5'd0;
      end else if (en) begin
         s1_valid_reg <= io_in_valid;
         s2_valid_reg <= s1_valid_reg;
         s3_valid_reg <= s2_valid_reg;
         s1_sign_reg  <= s1_sign_next;
         s1_mag_reg   <= s1_mag_next;
         s1_rnd_reg   <= s1_rnd_next;
         s2_sign_reg  <= s1_sign_reg;
         s2_norm_reg  <= s2_norm_next;
         s2_p_reg     <= s2_p_next;
         s2_zero_reg  <= s2_zero_next;
         s2_rnd_reg   <= s1_rnd_reg;
         s3_out_reg   <= s3_out_next;
         s3_flags_reg <= s3_flags_next;
      end
   end

endmodule
